// File: rtl/linear_out_pkg.sv
// Shared definitions for the tanh output stage: region codes, exponent bounds and FP constants.
// Imported by the region decoder, the output selector and the bus interface.
package linear_out_pkg;

    typedef enum logic [1:0] {
        HYPERBOLIC = 2'd0,
        SATURATION = 2'd1,
        LINEAR     = 2'd2
    } region_e;

    // Biased-exponent bounds: e < LIN_EXP is linear, e >= SAT_EXP saturates.
    localparam int unsigned LIN_EXP_DEF = 123;
    localparam int unsigned SAT_EXP_DEF = 130;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Signed unit value, used as the saturated tanh result.
    function automatic logic [31:0] fp_unit(input logic sign);
        return {sign, FP_ONE[30:0]};
    endfunction

endpackage

// File: rtl/linear_out_if.sv
// Operand/region/result bundle between the tanh front end and the output stage.
// master drives x and region and receives y; slave is the output stage.
interface linear_out_if;
    import linear_out_pkg::*;

    logic [31:0] x;
    logic [1:0]  region;
    logic [31:0] y;

    modport master (output x, output region, input y);
    modport slave  (input x, input region, output y);
endinterface

// File: rtl/linear_out_regions.sv
// Registered tanh region classifier on the operand exponent; 1 cycle latency, no backpressure.
// NaN is forced to LINEAR so it flows through the output stage untouched.
module regions
    import linear_out_pkg::*;
#(
    parameter int unsigned LIN_EXP = LIN_EXP_DEF,
    parameter int unsigned SAT_EXP = SAT_EXP_DEF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] x,
    output logic [1:0]  region
);

    localparam logic [7:0] LIN_E = LIN_EXP[7:0];
    localparam logic [7:0] SAT_E = SAT_EXP[7:0];

    logic [7:0]  exp_w;
    logic        is_nan;
    region_e     region_d;
    region_e     region_q;

    assign exp_w  = x[30:23];
    assign is_nan = (exp_w == 8'hFF) && (x[22:0] != 23'd0);

    // Zero and denormals fall below LIN_E; infinities land at or above SAT_E.
    always_comb begin
        region_d = HYPERBOLIC;
        if (is_nan || (exp_w < LIN_E)) begin
            region_d = LINEAR;
        end else if (exp_w >= SAT_E) begin
            region_d = SATURATION;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            region_q <= HYPERBOLIC;
        end else begin
            region_q <= region_d;
        end
    end

    assign region = region_q;

endmodule

// File: rtl/linear_out.sv
// tanh output stage for the linear and saturated regions: x -> y in 2 cycles, region aligned at stage 1.
// No handshake: one operand accepted per cycle, no backpressure.
module linear_out
    import linear_out_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    linear_out_if.slave  bus
);

    logic [31:0] x_d_q;
    logic [31:0] y_d;
    logic [31:0] y_q;

    // x_d_q lines up with the registered region from the sibling classifier.
    always_comb begin
        y_d = FP_ZERO;
        case (bus.region)
            LINEAR:     y_d = x_d_q;
            SATURATION: y_d = fp_unit(x_d_q[31]);
            default:    y_d = FP_ZERO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            x_d_q <= FP_ZERO;
            y_q   <= FP_ZERO;
        end else begin
            x_d_q <= bus.x;
            y_q   <= y_d;
        end
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_linear_out.sv
// Bench for the regions + linear_out pair: table vectors, an analog sweep and a randomized stream.
module tb_linear_out;
    import linear_out_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic       ovr;
    logic [1:0] reg_code;

    always #5 clock = ~clock;

    linear_out_if bus ();

    // ovr forces the otherwise unreachable code 3 onto the region input.
    assign bus.region = ovr ? 2'd3 : reg_code;

    regions u_regions (
        .clock  (clock),
        .resetn (resetn),
        .x      (bus.x),
        .region (reg_code)
    );

    linear_out dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int vecs = 0;
    int errs = 0;

    logic [31:0] hx[$];
    bit          hr[$];
    bit          ho[$];

    typedef struct {
        logic [31:0] x;
        logic [1:0]  region;
        logic [31:0] y;
    } vec_t;

    vec_t tv[$];

    // Magnitude ordering of IEEE bit patterns: 0x3D800000 = 0.0625, 0x41000000 = 8.0.
    function automatic logic [1:0] region_ref(input logic [31:0] x);
        logic [30:0] mag;
        mag = x[30:0];
        if (mag > 31'h7F80_0000 || mag < 31'h3D80_0000) return 2'd2;
        if (mag >= 31'h4100_0000) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] lin_ref(input logic [31:0] x);
        case (region_ref(x))
            2'd2:    return x;
            2'd1:    return x[31] ? 32'hBF80_0000 : 32'h3F80_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] b;
        int          e;
        b = $realtobits(r);
        if (r == 0.0) return {b[63], 31'd0};
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic real sp2real(input logic [31:0] s);
        int e;
        if (s[30:23] == 8'd0) return 0.0;
        e = int'(s[30:23]) - 127 + 1023;
        return $bitstoreal({s[31], e[10:0], s[22:0], 29'd0});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge, compare to history model.
    task automatic step(input logic [31:0] x, input bit rstn, input bit ov);
        int n;
        @(negedge clock);
        bus.x  = x;
        resetn = rstn;
        ovr    = ov;
        hx.push_back(x);
        hr.push_back(!rstn);
        ho.push_back(ov);
        @(posedge clock);
        #1;
        n = hx.size() - 1;
        check("region", {30'd0, reg_code}, hr[n] ? 32'd0 : {30'd0, region_ref(x)});
        if (n == 0 || hr[n] || hr[n-1] || ho[n])
            check("y", bus.y, 32'd0);
        else
            check("y", bus.y, lin_ref(hx[n-1]));
    endtask

    initial begin
        bus.x  = 32'd0;
        resetn = 1'b0;
        ovr    = 1'b0;

        tv.push_back('{32'h3D00_0000, 2'd2, 32'h3D00_0000});
        tv.push_back('{32'hBD80_0000, 2'd0, 32'h0000_0000});
        tv.push_back('{32'h4120_0000, 2'd1, 32'h3F80_0000});
        tv.push_back('{32'hC100_0000, 2'd1, 32'hBF80_0000});
        tv.push_back('{32'h7F80_0000, 2'd1, 32'h3F80_0000});
        tv.push_back('{32'h7FC0_0000, 2'd2, 32'h7FC0_0000});
        tv.push_back('{32'h8000_0000, 2'd2, 32'h8000_0000});
        tv.push_back('{32'h0000_0001, 2'd2, 32'h0000_0001});
        tv.push_back('{32'h3D80_0000, 2'd0, 32'h0000_0000});
        tv.push_back('{32'h4100_0000, 2'd1, 32'h3F80_0000});
        tv.push_back('{32'h3D7F_FFFF, 2'd2, 32'h3D7F_FFFF});
        tv.push_back('{32'h40FF_FFFF, 2'd0, 32'h0000_0000});
        tv.push_back('{32'hFF80_0000, 2'd1, 32'hBF80_0000});
        tv.push_back('{32'hFFC0_0001, 2'd2, 32'hFFC0_0001});

        step(32'h1234_5678, 1'b0, 1'b0);
        step(32'h4120_0000, 1'b0, 1'b0);

        foreach (tv[i]) begin
            step(tv[i].x, 1'b1, 1'b0);
            check("tv_region", {30'd0, reg_code}, {30'd0, tv[i].region});
            step(32'd0, 1'b1, 1'b0);
            check("tv_y", bus.y, tv[i].y);
        end

        // Region code 3 must zero the output even for a linear operand.
        step(32'h3D00_0000, 1'b1, 1'b0);
        step(32'd0, 1'b1, 1'b1);
        check("r3_y", bus.y, 32'd0);

        begin
            real prev_r;
            prev_r = 0.0;
            for (int i = 0; i <= 125; i++) begin
                real         r;
                logic [31:0] xb;
                int          n;
                r  = -0.0625 + i * 0.001;
                xb = real2sp(r);
                step(xb, i != 60, 1'b0);
                n = hx.size() - 1;
                if (i > 0 && !hr[n] && !hr[n-1] && region_ref(hx[n-1]) == 2'd2) begin
                    real d;
                    d = sp2real(bus.y) - $tanh(prev_r);
                    if (d < 0.0) d = -d;
                    vecs++;
                    if (d >= 1e-4) begin
                        errs++;
                        $display("FAIL tanh_err: y=%h err=%g required < 1e-4", bus.y, d);
                    end
                end
                prev_r = r;
            end
        end

        for (int i = 0; i < 400; i++) begin
            logic [31:0] xr;
            logic [7:0]  e;
            case ($urandom_range(0, 3))
                0: xr = $urandom;
                1: begin
                    e  = 8'($urandom_range(123, 129));
                    xr = {1'($urandom_range(0, 1)), e, 23'($urandom)};
                end
                2: begin
                    e  = 8'($urandom_range(121, 132));
                    xr = {1'($urandom_range(0, 1)), e, 23'($urandom_range(0, 1)) * 23'h7F_FFFF};
                end
                default: begin
                    e  = 8'($urandom_range(0, 122));
                    xr = {1'($urandom_range(0, 1)), e, 23'($urandom)};
                end
            endcase
            step(xr, $urandom_range(0, 39) != 0, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
